// File: rtl/serializer_pkg.sv
// Shared types and width helpers for the parallel-to-serial stage.
// Imported by the interface and the serializer top.
package serializer_pkg;

    typedef enum logic {IDLE, SEND} ser_state_t;

    localparam int DATA_W_DEF = 16;

    function automatic int mod_w(input int dw);
        return $clog2(dw);
    endfunction

    // one extra bit so a full-word count of DATA_W fits without wrapping
    function automatic int cnt_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/serializer_if.sv
// Word-in / bit-out bundle between the word source, the serializer
// and the downstream deserializer.
interface serializer_if
    import serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    localparam int MOD_W = mod_w(DATA_W);

    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );

endinterface

// File: rtl/serializer.sv
// Parallel-to-serial stage: loads a word, shifts the top N bits out
// MSB first, one valid bit per clock, with busy back-pressure.
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk_i,
    input  logic        srst_n_i,
    serializer_if.slave bus
);
    localparam int MOD_W = mod_w(DATA_W);
    localparam int CNT_W = cnt_w(DATA_W);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.data_val_i) begin
                    state_d = SEND;
                    shift_d = bus.data_i;
                    if (bus.data_mod_i == '0) begin
                        cnt_d = CNT_W'(DATA_W);
                    end else begin
                        cnt_d = {1'b0, bus.data_mod_i};
                    end
                end
            end
            SEND: begin
                cnt_d = cnt_q - CNT_W'(1);
                // clearing on the last bit keeps the idle serial line at 0
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    shift_d = '0;
                end else begin
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ser_data_o     = shift_q[DATA_W-1];
    assign bus.ser_data_val_o = (state_q == SEND);
    assign bus.busy_o         = (state_q == SEND);

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: bit scoreboard, busy model
// and a behavioural 16-bit deserializer for loopback.
module tb_serializer;
    import serializer_pkg::*;

    logic clk = 1'b0;
    logic srst_n = 1'b0;

    serializer_if #(.DATA_W(16)) bus ();

    serializer #(.DATA_W(16)) dut (
        .clk_i    (clk),
        .srst_n_i (srst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int bits_seen = 0;
    int dcnt = 0;
    bit mon_en = 1'b0;
    bit loop_en = 1'b0;
    logic [15:0] deser = '0;
    logic exp_q[$];
    logic [15:0] word_q[$];

    // serial monitor: bit scoreboard plus loopback deserializer
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (bus.busy_o !== bus.ser_data_val_o) begin
                n_bad++;
                $display("FAIL busy_vs_val: busy %b val %b", bus.busy_o, bus.ser_data_val_o);
            end
            if (bus.ser_data_val_o === 1'b1) begin
                logic eb;
                n_cmp++;
                bits_seen++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_bit: got %b want none", bus.ser_data_o);
                end else begin
                    eb = exp_q.pop_front();
                    if (bus.ser_data_o !== eb) begin
                        n_bad++;
                        $display("FAIL ser_bit: got %b want %b", bus.ser_data_o, eb);
                    end
                end
                if (loop_en) begin
                    deser = {deser[14:0], bus.ser_data_o};
                    dcnt++;
                    if (dcnt == 16) begin
                        logic [15:0] ew;
                        dcnt = 0;
                        n_cmp++;
                        if (word_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL loop_word: got %h want none", deser);
                        end else begin
                            ew = word_q.pop_front();
                            if (deser !== ew) begin
                                n_bad++;
                                $display("FAIL loop_word: got %h want %h", deser, ew);
                            end
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (bus.ser_data_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_data: got %b want 0", bus.ser_data_o);
                end
            end
        end
    end

    // called at posedge+1; returns at posedge+1 of the cycle after the accept
    task automatic send_word(input logic [15:0] d, input logic [3:0] m);
        int n;
        n = (m == 4'd0) ? 16 : int'(m);
        for (int i = 0; i < 100 && bus.busy_o; i++) begin
            @(posedge clk);
            #1;
        end
        if (bus.busy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: busy %b want 0", bus.busy_o);
        end
        for (int i = 0; i < n; i++) exp_q.push_back(d[15-i]);
        if (loop_en) word_q.push_back(d);
        bus.data_i = d;
        bus.data_mod_i = m;
        bus.data_val_i = 1'b1;
        @(posedge clk);
        #1;
        bus.data_val_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !bus.busy_o) break;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (exp_q.size() != 0 || bus.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: left %0d busy %b want 0 0", exp_q.size(), bus.busy_o);
        end
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        bus.data_i = 16'hFFFF;
        bus.data_mod_i = 4'd0;
        bus.data_val_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_data_val_o, bus.busy_o, bus.ser_data_o} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_out: val/busy/data %b%b%b want 000",
                         bus.ser_data_val_o, bus.busy_o, bus.ser_data_o);
            end
        end
        srst_n = 1'b1;
        bus.data_val_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nostart: busy %b want 0", bus.busy_o);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_len(input logic [15:0] d, input logic [3:0] m, input int n);
        int bc;
        send_word(d, m);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy_o) bc++;
            else break;
        end
        n_cmp++;
        if (bc != n) begin
            n_bad++;
            $display("FAIL busy_len: got %0d want %0d", bc, n);
        end
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_back_pressure();
        int rem;
        int n;
        logic [15:0] d;
        logic [3:0] m;
        logic eb;
        rem = 0;
        for (int c = 0; c < 60; c++) begin
            d = c[0] ? 16'h9C00 : 16'hA5C3;
            m = c[0] ? 4'd6 : 4'd0;
            n = c[0] ? 6 : 16;
            bus.data_i = d;
            bus.data_mod_i = m;
            bus.data_val_i = 1'b1;
            eb = (rem != 0);
            if (rem == 0) begin
                for (int i = 0; i < n; i++) exp_q.push_back(d[15-i]);
                rem = n;
            end else begin
                rem--;
            end
            @(negedge clk);
            n_cmp++;
            if (bus.busy_o !== eb) begin
                n_bad++;
                $display("FAIL bp_busy: cycle %0d got %b want %b", c, bus.busy_o, eb);
            end
            @(posedge clk);
            #1;
        end
        bus.data_val_i = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int b0;
        b0 = bits_seen;
        send_word(16'hFFFF, 4'd0);
        for (int i = 0; i < 40 && bits_seen < b0 + 4; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (bits_seen != b0 + 5) begin
            n_bad++;
            $display("FAIL mid_bits: got %0d want 5", bits_seen - b0);
        end
        srst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({bus.ser_data_val_o, bus.busy_o, bus.ser_data_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset: val/busy/data %b%b%b want 000",
                     bus.ser_data_val_o, bus.busy_o, bus.ser_data_o);
        end
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        send_word(16'h8001, 4'd0);
        wait_idle();
    endtask

    task automatic test_loopback();
        loop_en = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 50; i++) send_word(16'($urandom), 4'd0);
        wait_idle();
        n_cmp++;
        if (word_q.size() != 0 || dcnt != 0) begin
            n_bad++;
            $display("FAIL loop_drain: words %0d bits %0d want 0 0", word_q.size(), dcnt);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        bus.data_i = '0;
        bus.data_mod_i = '0;
        bus.data_val_i = 1'b0;
        test_reset();
        test_len(16'hA5C3, 4'd0, 16);
        test_len(16'hF000, 4'd3, 3);
        test_len(16'h4000, 4'd1, 1);
        test_len(16'h5555, 4'd15, 15);
        test_back_pressure();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
